spi_xip_ctrl: RTL

//  Execute-in-place sequencer placed between the APB flash window and the SPI master core's register bus.
//  - APB read in [FLASH_BASE,FLASH_END]: programs the core for one 64-bit transfer (cmd 0x03 + 24-bit address
//    + 32 data bits), polls GO_BSY, then returns RX0 byte-swapped to little-endian.
//  - Any other APB access passes straight through to the core registers.

---
 rtl/spi_xip_pkg.sv | 45 ++++
 rtl/spi_xip_bus_req.sv | 57 +++++
 rtl/spi_xip_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_xip_pkg.sv
// Shared constants, state encoding and bus payload for the SPI execute-in-place sequencer.
package spi_xip_pkg;

  localparam int unsigned ADR_W = 5;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  localparam logic [ADR_W-1:0] OFS_RX0  = 5'h00;
  localparam logic [ADR_W-1:0] OFS_TX1  = 5'h04;
  localparam logic [ADR_W-1:0] OFS_CTRL = 5'h10;
  localparam logic [ADR_W-1:0] OFS_DIV  = 5'h14;
  localparam logic [ADR_W-1:0] OFS_SS   = 5'h18;

  localparam int unsigned CTRL_GO_BSY = 8;
  localparam int unsigned CTRL_TX_NEG = 10;
  localparam int unsigned CTRL_ASS    = 13;
  localparam logic [6:0]  CHAR_LEN_64 = 7'd64;
  localparam logic [7:0]  CMD_READ    = 8'h03;

  // 64-bit transfer, drive on falling edge, auto slave select, start
  localparam logic [DAT_W-1:0] CTRL_XIP = DAT_W'(CHAR_LEN_64)
                                        | (DAT_W'(1) << CTRL_GO_BSY)
                                        | (DAT_W'(1) << CTRL_TX_NEG)
                                        | (DAT_W'(1) << CTRL_ASS);

  typedef enum logic [3:0] {
    IDLE, PASS, WR_DIV, WR_SS, WR_TX1, WR_CTRL, POLL, RD_RX, RESP
  } xip_state_e;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic             we;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } bus_req_t;

  function automatic logic [DAT_W-1:0] bswap32(input logic [DAT_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic is_xfer(input xip_state_e s);
    return (s != IDLE) && (s != RESP);
  endfunction

endpackage

// File: rtl/spi_xip_bus_req.sv
// Single core-register access: holds stb/cyc with a fixed request until ack or err,
// then drops strobe for a gap cycle in which done is pulsed and m_dat_i is valid.
module spi_xip_bus_req
  import spi_xip_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  bus_req_t         req,
  output logic [ADR_W-1:0] m_adr,
  output logic [DAT_W-1:0] m_dat_o,
  output logic [SEL_W-1:0] m_sel,
  output logic             m_we,
  output logic             m_stb,
  output logic             m_cyc,
  input  logic [DAT_W-1:0] m_dat_i,
  input  logic             m_ack,
  input  logic             m_err,
  output logic             done,
  output logic             err,
  output logic [DAT_W-1:0] rdata_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_adr   <= '0;
      m_dat_o <= '0;
      m_sel   <= '0;
      m_we    <= 1'b0;
      m_stb   <= 1'b0;
      m_cyc   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m_stb && (m_ack || m_err)) begin
        m_stb <= 1'b0;
        m_cyc <= 1'b0;
        m_we  <= 1'b0;
        m_sel <= '0;
        done  <= 1'b1;
        err   <= m_err;
      end else if (start && !m_stb) begin
        m_stb   <= 1'b1;
        m_cyc   <= 1'b1;
        m_adr   <= req.adr;
        m_we    <= req.we;
        m_dat_o <= req.dat;
        m_sel   <= req.sel;
      end
    end
  end

  // core holds read data after ack, so the gap cycle samples it directly
  assign rdata_c = m_dat_i;

endmodule

// File: rtl/spi_xip_ctrl.sv
// Execute-in-place sequencer: APB reads in the flash window become SPI read transfers,
// everything else is forwarded to the SPI core registers.
module spi_xip_ctrl
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter logic [31:0] SPI_DIV    = 32'h0000_0001,
  parameter logic [7:0]  FLASH_SS   = 8'h01,
  parameter logic [15:0] POLL_MAX   = 16'd1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_paddr,
  input  logic             in_psel,
  input  logic             in_penable,
  input  logic             in_pwrite,
  input  logic [31:0]      in_pwdata,
  input  logic [3:0]       in_pstrb,
  output logic             in_pready,
  output logic [31:0]      in_prdata,
  output logic             in_pslverr,
  output logic [ADR_W-1:0] m_adr,
  output logic [DAT_W-1:0] m_dat_o,
  output logic [SEL_W-1:0] m_sel,
  output logic             m_we,
  output logic             m_stb,
  output logic             m_cyc,
  input  logic [DAT_W-1:0] m_dat_i,
  input  logic             m_ack,
  input  logic             m_err
);

  xip_state_e       state_q, state_d;
  logic             cfg_done_q, skip_q;
  logic [15:0]      poll_cnt_q;
  logic [23:0]      paddr_q;
  logic             pwrite_q;
  logic [31:0]      pwdata_q;
  logic [3:0]       pstrb_q;

  logic             hit_c, accept_c, start_c, cfg_set_c, cfg_clr_c, poll_inc_c;
  logic             rsp_err_c;
  logic [31:0]      rsp_data_c;
  bus_req_t         req_c;
  logic             req_done, req_err;
  logic [DAT_W-1:0] req_rdata_c;

  function automatic bus_req_t req_for(input xip_state_e st, input logic [23:0] adr,
                                       input logic we, input logic [31:0] wdata,
                                       input logic [3:0] strb);
    bus_req_t r;
    r.adr = OFS_RX0;
    r.we  = 1'b0;
    r.dat = '0;
    r.sel = '1;
    case (st)
      PASS:    begin r.adr = adr[4:0]; r.we = we; r.dat = wdata; r.sel = strb; end
      WR_DIV:  begin r.adr = OFS_DIV;  r.we = 1'b1; r.dat = SPI_DIV; end
      WR_SS:   begin r.adr = OFS_SS;   r.we = 1'b1; r.dat = DAT_W'(FLASH_SS); end
      WR_TX1:  begin r.adr = OFS_TX1;  r.we = 1'b1; r.dat = {CMD_READ, adr[23:2], 2'b00}; end
      WR_CTRL: begin r.adr = OFS_CTRL; r.we = 1'b1; r.dat = CTRL_XIP; end
      POLL:    r.adr = OFS_CTRL;
      default: r.adr = OFS_RX0;
    endcase
    return r;
  endfunction

  spi_xip_bus_req u_bus_req (
    .clk     (clk),
    .rst     (rst),
    .start   (start_c),
    .req     (req_c),
    .m_adr   (m_adr),
    .m_dat_o (m_dat_o),
    .m_sel   (m_sel),
    .m_we    (m_we),
    .m_stb   (m_stb),
    .m_cyc   (m_cyc),
    .m_dat_i (m_dat_i),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .done    (req_done),
    .err     (req_err),
    .rdata_c (req_rdata_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    start_c    = 1'b0;
    cfg_set_c  = 1'b0;
    cfg_clr_c  = 1'b0;
    poll_inc_c = 1'b0;
    rsp_err_c  = 1'b0;
    rsp_data_c = '0;
    req_c      = '0;
    hit_c      = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
    case (state_q)
      IDLE: begin
        if (in_psel && in_penable && !in_pready && !skip_q) begin
          accept_c = 1'b1;
          if (hit_c && in_pwrite) begin
            state_d   = RESP;
            rsp_err_c = 1'b1;
          end else if (hit_c) begin
            state_d = cfg_done_q ? WR_TX1 : WR_DIV;
          end else begin
            state_d = PASS;
          end
        end
      end
      PASS: begin
        if (req_done) begin
          state_d    = RESP;
          rsp_data_c = req_rdata_c;
          rsp_err_c  = req_err;
          // rewriting DIVIDER or SS behind our back invalidates the flash setup
          if (pwrite_q && ((paddr_q[4:0] == OFS_DIV) || (paddr_q[4:0] == OFS_SS)))
            cfg_clr_c = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: begin
        if (req_done) begin
          if (req_err) begin
            state_d   = RESP;
            rsp_err_c = 1'b1;
            cfg_clr_c = 1'b1;
          end else begin
            case (state_q)
              WR_DIV:  state_d = WR_SS;
              WR_SS:   begin state_d = WR_TX1; cfg_set_c = 1'b1; end
              WR_TX1:  state_d = WR_CTRL;
              WR_CTRL: state_d = POLL;
              POLL: begin
                if (!req_rdata_c[CTRL_GO_BSY]) begin
                  state_d = RD_RX;
                end else if (poll_cnt_q < POLL_MAX) begin
                  poll_inc_c = 1'b1;
                end else begin
                  state_d   = RESP;
                  rsp_err_c = 1'b1;
                end
              end
              RD_RX: begin
                state_d    = RESP;
                rsp_data_c = bswap32(req_rdata_c);
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
    endcase
    // launch the next access on the same cycle the current one completes
    if ((accept_c || req_done) && is_xfer(state_d)) begin
      start_c = 1'b1;
      if (state_q == IDLE)
        req_c = req_for(state_d, in_paddr[23:0], in_pwrite, in_pwdata, in_pstrb);
      else
        req_c = req_for(state_d, paddr_q, pwrite_q, pwdata_q, pstrb_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_done_q <= 1'b0;
      poll_cnt_q <= '0;
      skip_q     <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      in_pready  <= 1'b0;
      in_prdata  <= '0;
      in_pslverr <= 1'b0;
    end else begin
      skip_q <= (state_q == RESP);
      if (accept_c) begin
        paddr_q  <= in_paddr[23:0];
        pwrite_q <= in_pwrite;
        pwdata_q <= in_pwdata;
        pstrb_q  <= in_pstrb;
      end
      if (cfg_clr_c)      cfg_done_q <= 1'b0;
      else if (cfg_set_c) cfg_done_q <= 1'b1;
      if (state_q == RESP) poll_cnt_q <= '0;
      else if (poll_inc_c) poll_cnt_q <= poll_cnt_q + 16'd1;
      in_pready  <= (state_d == RESP);
      in_prdata  <= (state_d == RESP) ? rsp_data_c : '0;
      in_pslverr <= (state_d == RESP) && rsp_err_c;
    end
  end

endmodule
